// File: rtl/sonar_varredura.sv
// Sonar sweep sequencer: steps the servo, waits for settling, requests a
// distance measurement and hands the result with its position to the transmitter.
`timescale 1ns/1ps
module sonar_varredura #(
    parameter int N_POSICOES     = 8,
    parameter int INTERVALO      = 2_000_000,
    parameter int TIMEOUT        = 3_000_000,
    parameter int LARGURA_MEDIDA = 12,
    parameter int LP             = $clog2(N_POSICOES)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ligar,
    input  logic                      parar,
    input  logic                      modo,
    input  logic                      fim_medida,
    input  logic [LARGURA_MEDIDA-1:0] medida,
    input  logic                      fim_transmissao,
    output logic [LP-1:0]             posicao,
    output logic                      medir,
    output logic                      transmitir,
    output logic [LARGURA_MEDIDA-1:0] dado_medida,
    output logic [LP-1:0]             dado_posicao,
    output logic                      erro_medida,
    output logic                      pronto,
    output logic [3:0]                db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        ESPERA         = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        PROXIMA        = 4'd6,
        FIM            = 4'd7
    } estado_t;

    // One counter serves both the settling interval and the measurement timeout.
    localparam int MAXC = (INTERVALO > TIMEOUT) ? INTERVALO : TIMEOUT;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] FIM_INTERVALO = CW'(INTERVALO - 1);
    localparam logic [CW-1:0] FIM_TIMEOUT   = CW'(TIMEOUT - 1);
    localparam logic [LP-1:0] POS_MAX       = LP'(N_POSICOES - 1);

    estado_t                   estado_q, estado_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [LP-1:0]             posicao_q, posicao_d;
    logic                      sobe_q, sobe_d;
    logic                      modo_q, modo_d;
    logic [LARGURA_MEDIDA-1:0] dado_medida_q, dado_medida_d;
    logic [LP-1:0]             dado_posicao_q, dado_posicao_d;
    logic                      erro_q, erro_d;

    always_comb begin
        estado_d       = estado_q;
        cnt_d          = '0;
        posicao_d      = posicao_q;
        sobe_d         = sobe_q;
        modo_d         = modo_q;
        dado_medida_d  = dado_medida_q;
        dado_posicao_d = dado_posicao_q;
        erro_d         = erro_q;

        if (parar) begin
            estado_d = INICIAL;
        end else begin
            case (estado_q)
                INICIAL: begin
                    if (ligar) begin
                        estado_d = ESPERA;
                        modo_d   = modo;
                    end
                end
                ESPERA: begin
                    if (cnt_q == FIM_INTERVALO) estado_d = MEDE;
                    else                        cnt_d    = cnt_q + 1'b1;
                end
                MEDE: estado_d = AGUARDA_MEDIDA;
                AGUARDA_MEDIDA: begin
                    // A real result arriving on the timeout cycle still wins.
                    if (fim_medida) begin
                        dado_medida_d  = medida;
                        dado_posicao_d = posicao_q;
                        erro_d         = 1'b0;
                        estado_d       = TRANSMITE;
                    end else if (cnt_q == FIM_TIMEOUT) begin
                        dado_medida_d  = '1;
                        dado_posicao_d = posicao_q;
                        erro_d         = 1'b1;
                        estado_d       = TRANSMITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                TRANSMITE: estado_d = AGUARDA_TX;
                AGUARDA_TX: begin
                    if (fim_transmissao) estado_d = PROXIMA;
                end
                PROXIMA: begin
                    if (modo_q) begin
                        if (posicao_q == POS_MAX) begin
                            estado_d  = FIM;
                            posicao_d = '0;
                            sobe_d    = 1'b1;
                        end else begin
                            estado_d  = ESPERA;
                            posicao_d = posicao_q + 1'b1;
                        end
                    end else begin
                        // Ping-pong: turn around at an endpoint without repeating it.
                        estado_d = ESPERA;
                        if (sobe_q) begin
                            if (posicao_q == POS_MAX) begin
                                sobe_d    = 1'b0;
                                posicao_d = posicao_q - 1'b1;
                            end else begin
                                posicao_d = posicao_q + 1'b1;
                            end
                        end else begin
                            if (posicao_q == '0) begin
                                sobe_d    = 1'b1;
                                posicao_d = posicao_q + 1'b1;
                            end else begin
                                posicao_d = posicao_q - 1'b1;
                            end
                        end
                    end
                end
                FIM:     estado_d = INICIAL;
                default: estado_d = INICIAL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= INICIAL;
            cnt_q          <= '0;
            posicao_q      <= '0;
            sobe_q         <= 1'b1;
            modo_q         <= 1'b0;
            dado_medida_q  <= '0;
            dado_posicao_q <= '0;
            erro_q         <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cnt_q          <= cnt_d;
            posicao_q      <= posicao_d;
            sobe_q         <= sobe_d;
            modo_q         <= modo_d;
            dado_medida_q  <= dado_medida_d;
            dado_posicao_q <= dado_posicao_d;
            erro_q         <= erro_d;
        end
    end

    assign posicao      = posicao_q;
    assign medir        = (estado_q == MEDE);
    assign transmitir   = (estado_q == TRANSMITE);
    assign pronto       = (estado_q == FIM);
    assign db_estado    = estado_q;
    assign dado_medida  = dado_medida_q;
    assign dado_posicao = dado_posicao_q;
    assign erro_medida  = erro_q;

endmodule

// File: tb/tb_sonar_varredura.sv
// Directed bench for sonar_varredura with N_POSICOES=4, INTERVALO=10, TIMEOUT=50.
`timescale 1ns/1ps
module tb_sonar_varredura;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ligar = 1'b0;
    logic        parar = 1'b0;
    logic        modo = 1'b0;
    logic        fim_medida = 1'b0;
    logic [11:0] medida = '0;
    logic        fim_transmissao = 1'b0;
    logic [1:0]  posicao;
    logic        medir;
    logic        transmitir;
    logic [11:0] dado_medida;
    logic [1:0]  dado_posicao;
    logic        erro_medida;
    logic        pronto;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;

    sonar_varredura #(
        .N_POSICOES(4),
        .INTERVALO(10),
        .TIMEOUT(50),
        .LARGURA_MEDIDA(12)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ligar(ligar),
        .parar(parar),
        .modo(modo),
        .fim_medida(fim_medida),
        .medida(medida),
        .fim_transmissao(fim_transmissao),
        .posicao(posicao),
        .medir(medir),
        .transmitir(transmitir),
        .dado_medida(dado_medida),
        .dado_posicao(dado_posicao),
        .erro_medida(erro_medida),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          n;
        logic        ligar;
        logic        parar;
        logic        modo;
        logic        fim_m;
        logic [11:0] medida;
        logic        fim_tx;
        logic [3:0]  e_estado;
        logic [1:0]  e_pos;
        logic        e_medir;
        logic        e_tx;
        logic [11:0] e_dado;
        logic        e_erro;
    } vetor_t;

    vetor_t tab[15];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        ligar = 1'b0;
        parar = 1'b0;
        fim_medida = 1'b0;
        fim_transmissao = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_estado"}, 32'(db_estado), 32'd0);
        chk({tag, "_posicao"}, 32'(posicao), 32'd0);
        chk({tag, "_medir"}, 32'(medir), 32'd0);
        chk({tag, "_transmitir"}, 32'(transmitir), 32'd0);
        chk({tag, "_pronto"}, 32'(pronto), 32'd0);
        chk({tag, "_dado_medida"}, 32'(dado_medida), 32'd0);
        chk({tag, "_dado_posicao"}, 32'(dado_posicao), 32'd0);
        chk({tag, "_erro"}, 32'(erro_medida), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Steps until medir is seen; n is the number of edges taken.
    task automatic espera_medir(output int n);
        n = 0;
        while (medir !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    // Called on the first ESPERA cycle; returns in PROXIMA.
    task automatic medicao(input logic [1:0] p, input logic [11:0] v);
        int n;
        espera_medir(n);
        chk("intervalo", 32'(n), 32'd10);
        chk("posicao_medir", 32'(posicao), 32'(p));
        repeat (4) step();
        fim_medida = 1'b1;
        medida = v;
        step();
        chk("transmitir", 32'(transmitir), 32'd1);
        chk("dado_medida", 32'(dado_medida), 32'(v));
        chk("dado_posicao", 32'(dado_posicao), 32'(p));
        chk("erro_medida", 32'(erro_medida), 32'd0);
        repeat (19) step();
        fim_transmissao = 1'b1;
        step();
        chk("estado_proxima", 32'(db_estado), 32'd6);
    endtask

    initial begin
        logic [1:0] seq[8];
        int n;
        int cnt_medir;
        int cnt_pronto;

        //            n  lig par mod fm  medida   ftx est pos med tx  dado     erro
        tab[0]  = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 4'd1, 2'd0, 1'b0, 1'b0, 12'h000, 1'b0};
        tab[1]  = '{9, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 4'd1, 2'd0, 1'b0, 1'b0, 12'h000, 1'b0};
        tab[2]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 4'd2, 2'd0, 1'b1, 1'b0, 12'h000, 1'b0};
        tab[3]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 4'd3, 2'd0, 1'b0, 1'b0, 12'h000, 1'b0};
        tab[4]  = '{4, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 4'd3, 2'd0, 1'b0, 1'b0, 12'h000, 1'b0};
        tab[5]  = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0, 4'd4, 2'd0, 1'b0, 1'b1, 12'h123, 1'b0};
        tab[6]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0, 4'd5, 2'd0, 1'b0, 1'b0, 12'h123, 1'b0};
        tab[7]  = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h456, 1'b0, 4'd5, 2'd0, 1'b0, 1'b0, 12'h123, 1'b0};
        tab[8]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b1, 4'd6, 2'd0, 1'b0, 1'b0, 12'h123, 1'b0};
        tab[9]  = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0, 4'd1, 2'd1, 1'b0, 1'b0, 12'h123, 1'b0};
        tab[10] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b1, 4'd1, 2'd1, 1'b0, 1'b0, 12'h123, 1'b0};
        tab[11] = '{8, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0, 4'd1, 2'd1, 1'b0, 1'b0, 12'h123, 1'b0};
        tab[12] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0, 4'd2, 2'd1, 1'b1, 1'b0, 12'h123, 1'b0};
        tab[13] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h456, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 12'h123, 1'b0};
        tab[14] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 12'h123, 1'b0};

        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};

        #1;
        chk_reset("reset_inicial");
        do_reset();
        chk_reset("pos_reset");

        for (int i = 0; i < 15; i++) begin
            ligar = tab[i].ligar;
            parar = tab[i].parar;
            modo = tab[i].modo;
            fim_medida = tab[i].fim_m;
            medida = tab[i].medida;
            fim_transmissao = tab[i].fim_tx;
            for (int c = 0; c < tab[i].n; c++) step();
            chk($sformatf("tab%0d_estado", i), 32'(db_estado), 32'(tab[i].e_estado));
            chk($sformatf("tab%0d_posicao", i), 32'(posicao), 32'(tab[i].e_pos));
            chk($sformatf("tab%0d_medir", i), 32'(medir), 32'(tab[i].e_medir));
            chk($sformatf("tab%0d_transmitir", i), 32'(transmitir), 32'(tab[i].e_tx));
            chk($sformatf("tab%0d_dado", i), 32'(dado_medida), 32'(tab[i].e_dado));
            chk($sformatf("tab%0d_erro", i), 32'(erro_medida), 32'(tab[i].e_erro));
        end

        // Continuous ping-pong sweep, then stop during ESPERA at position 2.
        do_reset();
        modo = 1'b0;
        ligar = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            medicao(seq[i], 12'h123);
            step();
            chk("estado_espera", 32'(db_estado), 32'd1);
        end
        chk("posicao_antes_parar", 32'(posicao), 32'd2);
        repeat (3) step();
        parar = 1'b1;
        ligar = 1'b1;
        step();
        chk("parar_estado", 32'(db_estado), 32'd0);
        chk("parar_posicao", 32'(posicao), 32'd2);
        cnt_medir = 0;
        repeat (20) begin
            step();
            if (medir === 1'b1) cnt_medir++;
        end
        chk("parar_sem_medir", 32'(cnt_medir), 32'd0);
        chk("parar_estado_final", 32'(db_estado), 32'd0);

        // Single sweep.
        do_reset();
        modo = 1'b1;
        ligar = 1'b1;
        step();
        modo = 1'b0;
        for (int p = 0; p < 4; p++) begin
            medicao(2'(p), 12'h100 + 12'(p));
            step();
            if (p < 3) begin
                chk("unica_estado", 32'(db_estado), 32'd1);
                chk("unica_posicao", 32'(posicao), 32'(p + 1));
            end
        end
        chk("fim_estado", 32'(db_estado), 32'd7);
        chk("fim_pronto", 32'(pronto), 32'd1);
        chk("fim_posicao", 32'(posicao), 32'd0);
        step();
        chk("fim_inicial", 32'(db_estado), 32'd0);
        cnt_medir = 0;
        cnt_pronto = 0;
        repeat (30) begin
            if (medir === 1'b1) cnt_medir++;
            if (pronto === 1'b1) cnt_pronto++;
            step();
        end
        chk("unica_sem_medir", 32'(cnt_medir), 32'd0);
        chk("unica_sem_pronto", 32'(cnt_pronto), 32'd0);

        // Measurement timeout, recovery, and fim_medida on the timeout cycle.
        do_reset();
        ligar = 1'b1;
        step();
        espera_medir(n);
        chk("to_intervalo", 32'(n), 32'd10);
        step();
        n = 0;
        while (transmitir !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("to_ciclos", 32'(n), 32'd50);
        chk("to_dado", 32'(dado_medida), 32'hFFF);
        chk("to_erro", 32'(erro_medida), 32'd1);
        chk("to_dado_posicao", 32'(dado_posicao), 32'd0);
        step();
        fim_transmissao = 1'b1;
        step();
        step();
        medicao(2'd1, 12'h0AB);
        step();
        espera_medir(n);
        chk("limite_posicao", 32'(posicao), 32'd2);
        step();
        repeat (49) step();
        chk("limite_estado", 32'(db_estado), 32'd3);
        chk("limite_sem_tx", 32'(transmitir), 32'd0);
        fim_medida = 1'b1;
        medida = 12'h321;
        step();
        chk("limite_tx", 32'(transmitir), 32'd1);
        chk("limite_dado", 32'(dado_medida), 32'h321);
        chk("limite_erro", 32'(erro_medida), 32'd0);
        chk("limite_dado_posicao", 32'(dado_posicao), 32'd2);
        step();
        chk("aguarda_tx_estado", 32'(db_estado), 32'd5);

        // Asynchronous reset mid-cycle during AGUARDA_TX at position 2.
        #3;
        reset = 1'b1;
        #1;
        chk_reset("reset_assincrono");
        @(negedge clock);
        reset = 1'b0;
        ligar = 1'b1;
        step();
        espera_medir(n);
        chk("reinicio_intervalo", 32'(n), 32'd10);
        chk("reinicio_posicao", 32'(posicao), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
